// File: rtl/inflate_bit_reader_if.sv
// Handshake bundle between the byte FIFO / inflate decoders (master) and the bit reader (slave).
// Valid/ready: fifo_rdata is valid whenever !fifo_rempty; a byte moves on a clock edge where fifo_rinc=1.
interface inflate_bit_reader_if #(
    parameter int PEEK_W = 16,
    parameter int CNT_W  = 6,
    parameter int LEN_W  = $clog2(PEEK_W) + 1
);
    logic              flush;
    logic              fifo_rempty;
    logic [7:0]        fifo_rdata;
    logic              fifo_rinc;
    logic [PEEK_W-1:0] peek_bits;
    logic [CNT_W-1:0]  bit_cnt;
    logic              consume;
    logic [LEN_W-1:0]  consume_len;
    logic              align;
    logic              err_underrun;

    modport master (
        output flush, fifo_rempty, fifo_rdata, consume, consume_len, align,
        input  fifo_rinc, peek_bits, bit_cnt, err_underrun
    );

    modport slave (
        input  flush, fifo_rempty, fifo_rdata, consume, consume_len, align,
        output fifo_rinc, peek_bits, bit_cnt, err_underrun
    );
endinterface

// File: rtl/inflate_bit_reader.sv
// LSB-first bit buffer between the inflate byte FIFO and the Huffman/header decoders.
// Optional INFLATE_BITCNT_EN adds bits_total, a running count of dropped bits.
module inflate_bit_reader #(
    parameter int BUF_W  = 32,
    parameter int PEEK_W = 16,
    parameter int CNT_W  = 6
) (
    input  logic clk,
    input  logic rst_n,
    inflate_bit_reader_if.slave bus
`ifdef INFLATE_BITCNT_EN
    ,
    output logic [31:0] bits_total
`endif
);
    logic [BUF_W-1:0] buf_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             run_q;

    logic [CNT_W-1:0] req_len;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] cnt_after;
    logic [CNT_W-1:0] len2;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] cnt_rem;
    logic             underrun;
    logic             rinc;
    logic [BUF_W-1:0] buf_n;
    logic [CNT_W-1:0] cnt_n;

    always_comb begin
        req_len   = CNT_W'(bus.consume_len);
        underrun  = bus.consume && (req_len > cnt_q);
        len       = (bus.consume && !underrun) ? req_len : '0;
        cnt_after = cnt_q - len;
        // Low three bits of the remaining count are the leftover bits of the current byte.
        len2      = bus.align ? CNT_W'(cnt_after[2:0]) : '0;
        drop      = len + len2;
        cnt_rem   = cnt_q - drop;
        // run_q keeps the pop off during reset and in the first cycle after release.
        rinc      = run_q && !bus.fifo_rempty && !bus.flush && (cnt_rem <= CNT_W'(BUF_W - 8));
        buf_n     = buf_q >> drop;
        cnt_n     = cnt_rem;
        if (rinc) begin
            buf_n = buf_n | ({{(BUF_W-8){1'b0}}, bus.fifo_rdata} << cnt_rem);
            cnt_n = cnt_rem + CNT_W'(8);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (bus.flush) begin
                buf_q <= '0;
                cnt_q <= '0;
                err_q <= 1'b0;
            end else begin
                buf_q <= buf_n;
                cnt_q <= cnt_n;
                if (underrun) err_q <= 1'b1;
            end
        end
    end

`ifdef INFLATE_BITCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_total <= '0;
        end else if (bus.flush) begin
            bits_total <= '0;
        end else begin
            bits_total <= bits_total + 32'(drop);
        end
    end
`endif

    assign bus.fifo_rinc    = rinc;
    assign bus.peek_bits    = buf_q[PEEK_W-1:0];
    assign bus.bit_cnt      = cnt_q;
    assign bus.err_underrun = err_q;
endmodule

// File: tb/tb_inflate_bit_reader.sv
// Directed table-driven bench for inflate_bit_reader: one vector per clock cycle.
module tb_inflate_bit_reader;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    inflate_bit_reader_if #(.PEEK_W(16), .CNT_W(6)) bus ();

`ifdef INFLATE_BITCNT_EN
    logic [31:0] bits_total;
    inflate_bit_reader #(.BUF_W(32), .PEEK_W(16), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .bits_total(bits_total)
    );
`else
    inflate_bit_reader #(.BUF_W(32), .PEEK_W(16), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
`endif

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        has_byte;
        logic [7:0]  data;
        logic        flush;
        logic        consume;
        logic [4:0]  len;
        logic        align;
        logic        exp_rinc;
        logic [15:0] exp_peek;
        logic [5:0]  exp_cnt;
        logic        exp_err;
        logic [31:0] exp_total;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic hb, input logic [7:0] d, input logic fl,
                                input logic cs, input logic [4:0] ln, input logic al,
                                input logic er_rinc, input logic [15:0] pk, input logic [5:0] ct,
                                input logic er, input logic [31:0] tot);
        vec_t v;
        v.has_byte = hb; v.data = d; v.flush = fl; v.consume = cs; v.len = ln; v.align = al;
        v.exp_rinc = er_rinc; v.exp_peek = pk; v.exp_cnt = ct; v.exp_err = er; v.exp_total = tot;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] pk, input logic [5:0] ct,
                                 input logic er, input logic [31:0] tot);
        check({tag, " peek"}, 32'(bus.peek_bits), 32'(pk));
        check({tag, " cnt"},  32'(bus.bit_cnt), 32'(ct));
        check({tag, " err"},  32'(bus.err_underrun), 32'(er));
`ifdef INFLATE_BITCNT_EN
        check({tag, " total"}, bits_total, tot);
`else
        if (tot === 32'hxxxx_xxxx) $display("note: unknown total in %s", tag);
`endif
    endtask

    // driver: called at a negedge, returns at the following negedge
    task automatic apply(input string tag, input vec_t v);
        bus.fifo_rempty = !v.has_byte;
        bus.fifo_rdata  = v.data;
        bus.flush       = v.flush;
        bus.consume     = v.consume;
        bus.consume_len = v.len;
        bus.align       = v.align;
        #1;
        check({tag, " rinc"}, 32'(bus.fifo_rinc), 32'(v.exp_rinc));
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag, v.exp_peek, v.exp_cnt, v.exp_err, v.exp_total);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = mk(1, 8'hA5, 0, 0, 0,  0, 1, 16'h00A5, 8,  0, 0);
        vecs[1]  = mk(1, 8'h3C, 0, 0, 0,  0, 1, 16'h3CA5, 16, 0, 0);
        vecs[2]  = mk(0, 8'h00, 0, 1, 3,  0, 0, 16'h0794, 13, 0, 3);
        vecs[3]  = mk(0, 8'h00, 0, 0, 0,  1, 0, 16'h003C, 8,  0, 8);
        vecs[4]  = mk(0, 8'h00, 0, 0, 0,  1, 0, 16'h003C, 8,  0, 8);
        vecs[5]  = mk(0, 8'h00, 0, 1, 0,  0, 0, 16'h003C, 8,  0, 8);
        vecs[6]  = mk(1, 8'h81, 0, 1, 4,  0, 1, 16'h0813, 12, 0, 12);
        vecs[7]  = mk(1, 8'hFF, 0, 1, 2,  1, 1, 16'hFF81, 16, 0, 16);
        vecs[8]  = mk(1, 8'h12, 0, 0, 0,  0, 1, 16'hFF81, 24, 0, 16);
        vecs[9]  = mk(1, 8'h34, 0, 0, 0,  0, 1, 16'hFF81, 32, 0, 16);
        vecs[10] = mk(1, 8'h56, 0, 0, 0,  0, 0, 16'hFF81, 32, 0, 16);
        vecs[11] = mk(1, 8'h56, 0, 1, 16, 0, 1, 16'h3412, 24, 0, 32);
        vecs[12] = mk(1, 8'h78, 0, 1, 5,  1, 1, 16'h5634, 24, 0, 40);
        vecs[13] = mk(0, 8'h00, 0, 1, 16, 0, 0, 16'h0078, 8,  0, 56);
        vecs[14] = mk(0, 8'h00, 0, 1, 9,  0, 0, 16'h0078, 8,  1, 56);
        vecs[15] = mk(0, 8'h00, 0, 1, 8,  0, 0, 16'h0000, 0,  1, 64);
        vecs[16] = mk(1, 8'h99, 1, 0, 0,  0, 0, 16'h0000, 0,  0, 0);
        vecs[17] = mk(1, 8'h99, 0, 1, 1,  0, 1, 16'h0099, 8,  1, 0);
        vecs[18] = mk(1, 8'h99, 1, 0, 0,  0, 0, 16'h0000, 0,  0, 0);

        // reset with a byte already waiting in the FIFO
        rst_n           = 1'b0;
        bus.fifo_rempty = 1'b0;
        bus.fifo_rdata  = 8'hA5;
        bus.flush       = 1'b0;
        bus.consume     = 1'b0;
        bus.consume_len = '0;
        bus.align       = 1'b0;
        repeat (2) @(negedge clk);
        check("reset rinc", 32'(bus.fifo_rinc), 32'd0);
        check_outputs("reset", 16'h0, 6'd0, 1'b0, 32'd0);

        // release cycle: no pop allowed
        rst_n = 1'b1;
        #1;
        check("release rinc", 32'(bus.fifo_rinc), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_outputs("release", 16'h0, 6'd0, 1'b0, 32'd0);

        for (int i = 0; i < 19; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // underrun at cnt=4 leaves the buffer intact
        apply("ur_fill", mk(1, 8'hF0, 0, 0, 0, 0, 1, 16'h00F0, 8, 0, 0));
        apply("ur_c4",   mk(0, 8'h00, 0, 1, 4, 0, 0, 16'h000F, 4, 0, 4));
        apply("ur_c9",   mk(0, 8'h00, 0, 1, 9, 0, 0, 16'h000F, 4, 1, 4));

        // asynchronous reset in the middle of a cycle that would pop
        bus.fifo_rempty = 1'b0;
        bus.fifo_rdata  = 8'h11;
        bus.consume     = 1'b0;
        bus.align       = 1'b0;
        bus.flush       = 1'b0;
        #1;
        check("pre_arst rinc", 32'(bus.fifo_rinc), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst rinc", 32'(bus.fifo_rinc), 32'd0);
        check_outputs("arst", 16'h0, 6'd0, 1'b0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_rel rinc", 32'(bus.fifo_rinc), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_outputs("arst_rel", 16'h0, 6'd0, 1'b0, 32'd0);
        apply("post_arst", mk(1, 8'h11, 0, 0, 0, 0, 1, 16'h0011, 8, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global time bound
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
